// File: rtl/lsm_pkg.sv
// Shared types and width helpers for the Longstaff-Schwartz pricing core.
package lsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UPDATE,
    ACCUM,
    FINAL,
    DONE
  } state_e;

  localparam logic MODE_CALL = 1'b0;
  localparam logic MODE_PUT  = 1'b1;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(input int data_w, input int n_paths);
    return data_w + $clog2(n_paths);
  endfunction

endpackage

// File: rtl/lsm_discount.sv
// One-step discount y = (x*disc) >> DISC_W; LSM_ROUND_EN selects round-half-up
// with saturation instead of truncation.
module lsm_discount #(
  parameter int DATA_W = 12,
  parameter int DISC_W = 12
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DISC_W-1:0] disc,
  output logic [DATA_W-1:0] y
);

  localparam int PROD_W = DATA_W + DISC_W;

  logic [PROD_W-1:0] prod;

  assign prod = PROD_W'(x) * PROD_W'(disc);

`ifdef LSM_ROUND_EN
  localparam logic [PROD_W:0] HALF = (PROD_W + 1)'(1) << (DISC_W - 1);

  logic [PROD_W:0] rnd;
  logic [DATA_W:0] shr;
  logic            unused_low;

  assign rnd        = {1'b0, prod} + HALF;
  assign shr        = rnd[PROD_W:DISC_W];
  assign y          = shr[DATA_W] ? {DATA_W{1'b1}} : shr[DATA_W-1:0];
  assign unused_low = ^rnd[DISC_W-1:0];
`else
  logic unused_low;

  assign y          = prod[PROD_W-1:DISC_W];
  assign unused_low = ^prod[DISC_W-1:0];
`endif

endmodule

// File: rtl/lsm_pricer_core.sv
// Backward-streaming Longstaff-Schwartz American option pricer with a per-path
// cash-flow buffer. Define LSM_ROUND_EN for rounded discount and averaging.
module lsm_pricer_core
  import lsm_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int N_PATHS = 128,
  parameter int N_DAYS  = 8,
  parameter int DISC_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              put_mode,
  input  logic [DATA_W-1:0] strike,
  input  logic [DISC_W-1:0] disc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_price,
  input  logic [DATA_W-1:0] in_cont,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_price,
  output logic              busy
);

  localparam int IDX_W = idx_w(N_PATHS);
  localparam int DAY_W = idx_w(N_DAYS);
  localparam int SUM_W = sum_w(DATA_W, N_PATHS);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  path_q, path_d;
  logic [DAY_W-1:0]  day_q, day_d;
  logic              put_q, put_d;
  logic [DATA_W-1:0] strike_q, strike_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] out_price_q, out_price_d;

  // Sample stage: the buffer write lands one cycle after the handshake.
  logic              st_vld_q, st_vld_d;
  logic              st_load_q, st_load_d;
  logic [IDX_W-1:0]  st_idx_q, st_idx_d;
  logic [DATA_W-1:0] st_p_q, st_p_d;
  logic [DATA_W-1:0] st_cont_q, st_cont_d;

  logic [DATA_W-1:0] cf_q [N_PATHS];
  logic [DATA_W-1:0] cf_d;

  logic              accept;
  logic              last_path;
  logic [DATA_W-1:0] pay;
  logic [DATA_W-1:0] cf_disc;
  logic [SUM_W-1:0]  avg_full;
  logic [DATA_W-1:0] avg;
  logic [DATA_W-1:0] final_disc;
  logic              unused_avg;

  assign accept    = in_valid & in_ready;
  assign last_path = (path_q == IDX_W'(N_PATHS - 1));

  always_comb begin
    pay = '0;
    if (put_q == MODE_PUT) begin
      if (strike_q > in_price) pay = strike_q - in_price;
    end else begin
      if (in_price > strike_q) pay = in_price - strike_q;
    end
  end

`ifdef LSM_ROUND_EN
  assign avg_full = sum_q + SUM_W'(N_PATHS / 2);
`else
  assign avg_full = sum_q;
`endif
  assign avg        = avg_full[SUM_W-1:IDX_W];
  assign unused_avg = ^avg_full[IDX_W-1:0];

  lsm_discount #(.DATA_W(DATA_W), .DISC_W(DISC_W)) u_disc_update (
    .x    (cf_q[st_idx_q]),
    .disc (disc_q),
    .y    (cf_disc)
  );

  lsm_discount #(.DATA_W(DATA_W), .DISC_W(DISC_W)) u_disc_final (
    .x    (avg),
    .disc (disc_q),
    .y    (final_disc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && last_path) state_d = (N_DAYS > 1) ? UPDATE : ACCUM;
      UPDATE:  if (accept && last_path && day_q == '0) state_d = ACCUM;
      ACCUM:   if (last_path) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:         busy = 1'b0;
      LOAD, UPDATE: in_ready = 1'b1;
      DONE:         out_valid = 1'b1;
      default:      ;
    endcase
  end

  assign out_price = out_price_q;

  always_comb begin
    path_d      = path_q;
    day_d       = day_q;
    put_d       = put_q;
    strike_d    = strike_q;
    disc_d      = disc_q;
    sum_d       = sum_q;
    out_price_d = out_price_q;
    st_vld_d    = accept;
    st_load_d   = accept ? (state_q == LOAD) : st_load_q;
    st_idx_d    = accept ? path_q : st_idx_q;
    st_p_d      = accept ? pay : st_p_q;
    st_cont_d   = accept ? in_cont : st_cont_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          put_d    = put_mode;
          strike_d = strike;
          disc_d   = disc;
          path_d   = '0;
          day_d    = DAY_W'(N_DAYS - 1);
          sum_d    = '0;
        end
      end
      LOAD, UPDATE: begin
        if (accept) begin
          if (last_path) begin
            path_d = '0;
            if (day_q != '0) day_d = day_q - 1'b1;
          end else begin
            path_d = path_q + 1'b1;
          end
        end
      end
      ACCUM: begin
        sum_d  = sum_q + SUM_W'(cf_q[path_q]);
        path_d = last_path ? '0 : path_q + 1'b1;
      end
      FINAL:   out_price_d = final_disc;
      default: ;
    endcase
  end

  // Exercise when the immediate payoff beats continuation, else carry the discounted flow.
  always_comb begin
    cf_d = cf_disc;
    if (st_load_q || (st_p_q != '0 && st_p_q > st_cont_q)) cf_d = st_p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_q      <= '0;
      day_q       <= '0;
      put_q       <= 1'b0;
      strike_q    <= '0;
      disc_q      <= '0;
      sum_q       <= '0;
      out_price_q <= '0;
      st_vld_q    <= 1'b0;
      st_load_q   <= 1'b0;
      st_idx_q    <= '0;
      st_p_q      <= '0;
      st_cont_q   <= '0;
    end else begin
      path_q      <= path_d;
      day_q       <= day_d;
      put_q       <= put_d;
      strike_q    <= strike_d;
      disc_q      <= disc_d;
      sum_q       <= sum_d;
      out_price_q <= out_price_d;
      st_vld_q    <= st_vld_d;
      st_load_q   <= st_load_d;
      st_idx_q    <= st_idx_d;
      st_p_q      <= st_p_d;
      st_cont_q   <= st_cont_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PATHS; i++) cf_q[i] <= '0;
    end else if (st_vld_q) begin
      cf_q[st_idx_q] <= cf_d;
    end
  end

endmodule

// File: tb/tb_lsm_pricer_core.sv
// Scoreboard bench for lsm_pricer_core (4 paths, 2 dates): a behavioural pricing
// model feeds an expected-result queue that an independent monitor drains.
module tb_lsm_pricer_core;

  localparam int N  = 4;
  localparam int ND = 2;
  localparam int DW = 12;
  localparam int QW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          put_mode = 1'b0;
  logic [DW-1:0] strike = '0;
  logic [QW-1:0] disc = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_price = '0;
  logic [DW-1:0] in_cont = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_price;
  logic          busy;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  int     exp_q[$];
  longint lat_q[$];

  typedef int grid_t [ND][N];
  grid_t pr;
  grid_t co;

  lsm_pricer_core #(.DATA_W(DW), .N_PATHS(N), .N_DAYS(ND), .DISC_W(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .put_mode  (put_mode),
    .strike    (strike),
    .disc      (disc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_price  (in_price),
    .in_cont   (in_cont),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_price (out_price),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int payoff(input bit put, input int k, input int s);
    if (put) return (k > s) ? k - s : 0;
    return (s > k) ? s - k : 0;
  endfunction

  function automatic int dsc(input int x, input int d);
    longint p = longint'(x) * longint'(d);
`ifdef LSM_ROUND_EN
    p = (p + (longint'(1) << (QW - 1))) >> QW;
    if (p > (1 << DW) - 1) p = (1 << DW) - 1;
`else
    p = p >> QW;
`endif
    return int'(p);
  endfunction

  function automatic int model(input bit put, input int k, input int d);
    int     cf[N];
    longint sum = 0;
    int     p;
    int     avg;
    for (int i = 0; i < N; i++) cf[i] = payoff(put, k, pr[ND-1][i]);
    for (int dd = ND - 2; dd >= 0; dd--)
      for (int i = 0; i < N; i++) begin
        p = payoff(put, k, pr[dd][i]);
        cf[i] = (p > 0 && p > co[dd][i]) ? p : dsc(cf[i], d);
      end
    for (int i = 0; i < N; i++) sum += cf[i];
`ifdef LSM_ROUND_EN
    avg = int'((sum + N / 2) / N);
`else
    avg = int'(sum / N);
`endif
    return dsc(avg, d);
  endfunction

  // ---------------- monitor ----------------
  logic          ov_prev = 1'b0;
  logic          or_prev = 1'b0;
  logic          idle_chk = 1'b0;
  logic [DW-1:0] op_prev = '0;

  always @(negedge clk) begin
    int     e;
    longint t;
    if (rst_n) begin
      if (idle_chk) check("idle_after_done", {busy, out_valid}, 64'd0);
      if (ov_prev && !or_prev) begin
        check("valid_hold", out_valid, 64'd1);
        check("price_hold", out_price, op_prev);
      end
      if (out_valid && !ov_prev) begin
        check("in_ready_in_done", in_ready, 64'd0);
        if (lat_q.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
        else begin
          t = lat_q.pop_front();
          check("latency", cyc, t + N + 2);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("out_price", out_price, e);
          $display("result: out_price=%0d expected=%0d", out_price, e);
        end
      end
    end
    ov_prev  <= out_valid;
    or_prev  <= out_ready;
    op_prev  <= out_price;
    idle_chk <= rst_n && out_valid && out_ready;
  end

  // ---------------- stimulus ----------------
  task automatic load_test1();
    pr[1] = '{150, 90, 120, 100};
    pr[0] = '{130, 80, 110, 140};
    co[0] = '{40, 0, 30, 10};
    co[1] = '{999, 999, 999, 999};
  endtask

  task automatic load_random(input int pmax, input int cmax);
    for (int dd = 0; dd < ND; dd++)
      for (int i = 0; i < N; i++) begin
        pr[dd][i] = $urandom_range(pmax);
        co[dd][i] = $urandom_range(cmax);
      end
  endtask

  task automatic run_case(input bit put, input int k, input int d, input int gap_pct,
                          input int abort_at);
    int     e;
    int     idx;
    int     guard;
    bit     done;
    bit     gap;
    longint last;
    e = model(put, k, d);
    last = 0;
    guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    if (busy) begin
      check("idle_timeout", busy, 64'd0);
      return;
    end
    $display("run: put=%0d K=%0d disc=%0d gap=%0d abort_at=%0d expected=%0d",
             put, k, d, gap_pct, abort_at, e);
    put_mode = put;
    strike   = DW'(k);
    disc     = QW'(d);
    start    = 1'b1;
    tick();
    idx = 0;
    for (int dd = ND - 1; dd >= 0; dd--) begin
      for (int i = 0; i < N; i++) begin
        if (idx == abort_at) begin
          in_valid = 1'b0;
          start    = 1'b0;
          rst_n    = 1'b0;
          #1;
          check("reset_outputs", {in_ready, out_valid, busy, out_price}, 64'd0);
          tick();
          rst_n = 1'b1;
          return;
        end
        done  = 1'b0;
        guard = 0;
        while (!done) begin
          gap      = ($urandom_range(99) < gap_pct);
          in_valid = !gap;
          in_price = gap ? DW'($urandom) : DW'(pr[dd][i]);
          in_cont  = gap ? DW'($urandom) : DW'(co[dd][i]);
          start    = ($urandom_range(7) == 0);
          put_mode = 1'($urandom);
          strike   = DW'($urandom);
          disc     = QW'($urandom);
          done     = in_valid && in_ready;
          if (done) last = cyc;
          tick();
          if (!done) begin
            guard++;
            if (guard > 50) begin
              check("in_ready_timeout", 64'd0, 64'd1);
              in_valid = 1'b0;
              start    = 1'b0;
              return;
            end
          end
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    exp_q.push_back(e);
    lat_q.push_back(last);
    for (int c = 0; c < N + 1; c++) begin
      check("drain_flags", {in_ready, busy, out_valid}, 64'b010);
      tick();
    end
  endtask

  task automatic finish_case(input bit hold);
    int guard;
    if (hold) begin
      for (int c = 0; c < 10; c++) begin
        start    = 1'($urandom);
        strike   = DW'($urandom);
        put_mode = 1'($urandom);
        tick();
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    guard = 0;
    while (busy && guard < 50) begin
      tick();
      guard++;
    end
    check("done_timeout", busy, 64'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_state", {in_ready, out_valid, busy, out_price}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed call case, full throughput then with 50% input gaps.
    load_test1();
    run_case(1'b0, 100, 2048, 0, -1);
    finish_case(1'b0);
    load_test1();
    run_case(1'b0, 100, 2048, 50, -1);
    finish_case(1'b0);

    // Put case with the directed last-date prices.
    load_random(4095, 200);
    pr[1] = '{80, 120, 100, 60};
    run_case(1'b1, 100, 2048, 0, -1);
    finish_case(1'b0);

    // Back-pressure on the result with spurious starts during DONE.
    load_random(4095, 1500);
    out_ready = 1'b0;
    run_case(1'b0, 1500, 3000, 20, -1);
    finish_case(1'b1);

    // Reset in the middle of the second date, then a clean rerun.
    load_test1();
    run_case(1'b0, 100, 2048, 0, N + 1);
    load_test1();
    run_case(1'b0, 100, 2048, 0, -1);
    finish_case(1'b0);

    // Every payoff zero.
    load_random(4095, 4095);
    run_case(1'b0, 4095, 4095, 0, -1);
    finish_case(1'b0);

    for (int r = 0; r < 20; r++) begin
      load_random(4095, 1500);
      if (r % 5 == 4) out_ready = 1'b0;
      run_case(1'($urandom), $urandom_range(500, 3500), $urandom_range(4095),
               (r % 2) ? 30 : 0, -1);
      finish_case(r % 5 == 4);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("results_outstanding", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsm_pricer_core.md
# lsm_pricer_core

Parametrised Longstaff–Schwartz American-option pricing core, successor to the fixed 128-path/8-day Monte Carlo core. It streams simulated path prices backward in time, with a per-sample continuation estimate from the upstream regression unit, and keeps a per-path cash-flow buffer. At each exercise date it applies the exercise decision, then averages and discounts the buffer to produce one option price. It sits between the path generator/regression pipeline and the result register bank.

## Interface
- DATA_W, 12: width of prices, strike, continuation values, cash flows, result
- N_PATHS, 128: paths per run; power of two, ≥2
- N_DAYS, 8: exercise dates per run, ≥1
- DISC_W, 12: discount factor is unsigned fraction Q0.DISC_W
- clk in 1: clock
- rst_n in 1: reset, asynchronous, active-low
- start in 1: begin run; sampled only in IDLE
- put_mode in 1: 0 call, 1 put; latched with strike/disc at start
- strike in DATA_W: strike K
- disc in DISC_W: one-step discount factor
- in_valid in 1 / in_ready out 1: sample handshake
- in_price in DATA_W: path price
- in_cont in DATA_W: regression continuation estimate; ignored on last date
- out_valid out 1 / out_ready in 1: result handshake
- out_price out DATA_W: option price
- busy out 1: high in every state except IDLE

## Operation
- Sample order is date-major, from the last date down to date 0, then path 0..N_PATHS-1 within each date. Exactly N_PATHS*N_DAYS samples are accepted.
- Payoff p: call = S>K ? S−K : 0; put = K>S ? K−S : 0 (DATA_W, no overflow).
- Discount op D(x) = (x*disc)>>DISC_W, product width DATA_W+DISC_W.
- States and transitions:
  - IDLE → LOAD on start.
  - LOAD (last date): cf[i]=p. After the last path: → UPDATE if N_DAYS>1, else → ACCUM.
  - UPDATE: cf[i] = (p>0 && p>in_cont) ? p : D(cf[i]). After path N_PATHS−1 of date 0: → ACCUM.
  - ACCUM: sum += cf[j], j=0..N_PATHS−1, one entry/cycle. Sum width DATA_W+log2(N_PATHS); no overflow. → FINAL.
  - FINAL: out_price_next = D(sum>>log2(N_PATHS)). → DONE.
  - DONE: out_valid=1, out_price held. → IDLE on out_ready.
- start outside IDLE is ignored. strike/disc/put_mode changes after start have no effect.
- The cf buffer is not cleared between runs; LOAD overwrites every entry.

## Timing
- Reset values: in_ready 0, out_valid 0, out_price 0, busy 0, state IDLE, counters 0, cf buffer 0.
- in_ready = 1 exactly in LOAD/UPDATE; one sample per cycle at full throughput. Stalls (in_valid=0) hold all state.
- The cf update is registered in the cycle after the handshake. A read-modify-write of the same index never occurs back-to-back because indices advance sequentially.
- Last accepted sample at cycle t → out_valid at t+N_PATHS+2.
- out_valid with out_ready high in the same cycle returns to IDLE next cycle. A start in that IDLE cycle begins a new run.
- Reset mid-run: immediate return to reset values; the partial run is discarded.

## Configuration
- LSM_ROUND_EN defined: D() adds 2^(DISC_W−1) before the shift, and the average adds N_PATHS/2 before the shift (round half up; clamp D() result to 2^DATA_W−1).
- LSM_ROUND_EN undefined: both operations truncate.

## Structure
- Shared package lsm_pkg: state enum (IDLE, LOAD, UPDATE, ACCUM, FINAL, DONE), payoff-mode constants, clog2-derived index/sum width helpers.
- One sub-module, lsm_discount: the D() multiply-shift, with rounding under LSM_ROUND_EN. Instantiated twice: UPDATE path and FINAL.

## Test plan
- Call, N_PATHS=4, N_DAYS=2, K=100, disc=2048. Last date 150,90,120,100. Date 0 prices 130,80,110,140, cont 40,0,30,10 → cf 25,0,10,40 → out_price 9 (10 with LSM_ROUND_EN).
- Put, N_DAYS=1, K=100, disc=2048, prices 80,120,100,60 → out_price 7 (8 with LSM_ROUND_EN).
- Random in_valid gaps (50%) on the first test → identical out_price 9; in_ready low outside LOAD/UPDATE.
- out_ready held low 10 cycles → out_valid and out_price stable. start during the run and during DONE → ignored.
- rst_n asserted mid-UPDATE → all outputs return to reset values. A fresh run with the first test's data → 9.
- All payoffs zero (call, K=4095) → out_price 0. Latency exactly N_PATHS+2 from the last sample.
